// File: rtl/tri_arb_pkg.sv
// Shared types and the wrapped round-robin search used by the tristate bus arbiter.
package tri_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} tri_arb_state_e;

  localparam int MAX_NREQ = 16;

  // First set bit of req at or after ptr, wrapping modulo nreq; returns ptr when req is empty.
  function automatic int rr_idx(input logic [MAX_NREQ-1:0] req, input int ptr, input int nreq);
    int j;
    rr_idx = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      j = (ptr + k) % nreq;
      if (k < nreq && req[j[3:0]]) rr_idx = j;
    end
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between the driver sub-blocks and the tristate bus arbiter.
interface tri_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wr_data;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gnt_id;
  logic              busy;
  logic              timeout;
  logic [W-1:0]      bus_rd;

  modport master (output req, wr_data, input gnt, gnt_id, busy, timeout, bus_rd);
  modport slave  (input req, wr_data, output gnt, gnt_id, busy, timeout, bus_rd);

endinterface

// File: rtl/tri_arb_rr_pick.sv
// Combinational round-robin picker: index of the first request at or after ptr.
module tri_arb_rr_pick
  import tri_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);
  localparam int PW = $clog2(NREQ);

  logic [MAX_NREQ-1:0] req_w;

  always_comb begin
    req_w             = '0;
    req_w[NREQ-1:0]   = req_i;
  end

  assign idx_o = PW'(rr_idx(req_w, int'(ptr_i), NREQ));
  assign any_o = |req_i;

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of one shared tristate bus with a driverless turnaround gap.
// Define TRI_ARB_TIMEOUT_EN to revoke an owner after MAX_HOLD cycles when others wait.
//   state | meaning
//   IDLE  | bus floating, arbitrate every cycle
//   GRANT | one requester drives the bus until its req drops (or it is revoked)
//   TURN  | TURNAROUND cycles with no driver, arbitrate on the last one
module tri_bus_arbiter
  import tri_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int W          = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  tri_bus_arbiter_if.slave arb_if,
  inout  wire  [W-1:0]     bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TURNAROUND + 1);

  tri_arb_state_e  state_q;
  logic [NREQ-1:0] gnt_q;
  logic [PW-1:0]   gnt_id_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            busy_q;
  logic            timeout_q;
  logic            revoke_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    bus_rd_q;

  if (NREQ < 2 || NREQ > MAX_NREQ || TURNAROUND < 1 || MAX_HOLD < 2) begin : g_param_check
    $error("tri_bus_arbiter: parameter out of range");
  end

  tri_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (arb_if.req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef TRI_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hcnt_q;

  assign revoke_d = (hcnt_q == HW'(MAX_HOLD - 1)) && |(arb_if.req & ~gnt_q);

  // Zero outside GRANT, so it reads 0 in the first owned cycle; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                hcnt_q <= '0;
    else if (state_q != GRANT)              hcnt_q <= '0;
    else if (hcnt_q != HW'(MAX_HOLD - 1))   hcnt_q <= hcnt_q + 1'b1;
  end
`else
  assign revoke_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      bus_rd_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      bus_rd_q  <= bus;
      if (state_q == GRANT) begin
        if (!arb_if.req[gnt_id_q] || revoke_d) begin
          state_q   <= TURN;
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          cnt_q     <= CW'(TURNAROUND);
          timeout_q <= arb_if.req[gnt_id_q];
        end
      end else if (state_q == TURN && cnt_q != CW'(1)) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (pick_any) begin
        state_q  <= GRANT;
        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
        gnt_id_q <= pick_idx;
        busy_q   <= 1'b1;
        ptr_q    <= ptr_d;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign bus = busy_q ? arb_if.wr_data[gnt_id_q*W +: W] : {W{1'bz}};

  assign arb_if.gnt     = gnt_q;
  assign arb_if.gnt_id  = gnt_id_q;
  assign arb_if.busy    = busy_q;
  assign arb_if.timeout = timeout_q;
  assign arb_if.bus_rd  = bus_rd_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: directed scenarios plus random requests vs a reference model.
module tb_tri_bus_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TA  = 1;
  localparam int MH  = 8;
`ifdef TRI_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  wire [DW-1:0] bus;
  wire [DW-1:0] bus3;

  tri_bus_arbiter_if #(.NREQ(NR), .W(DW)) bif ();
  tri_bus_arbiter_if #(.NREQ(NR), .W(DW)) bif3 ();

  tri_bus_arbiter #(.NREQ(NR), .W(DW), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .arb_if(bif), .bus(bus)
  );

  tri_bus_arbiter #(.NREQ(NR), .W(DW), .TURNAROUND(3), .MAX_HOLD(16)) dut_t3 (
    .clk(clk), .rst(rst), .arb_if(bif3), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who owns the bus, where the rotation resumes, remaining gap, hold time
  int         m_owner;
  int         m_ptr;
  int         m_gap;
  int         m_hold;
  bit         m_tmo;
  bit         m_rd_float;
  logic [7:0] m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_float(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  function automatic logic [7:0] slice(input int i);
    return bif.wr_data[i*8 +: 8];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_gap = 0; m_hold = 0; m_tmo = 1'b0;
    m_rd_float = 1'b1; m_rd = '0;
  endtask

  task automatic model_step();
    logic [3:0] r;
    logic [3:0] others;
    bit found;
    int win;
    r = bif.req;
    m_rd_float = (m_owner < 0);
    if (m_owner >= 0) m_rd = slice(m_owner);
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = TA;
      end else if (TMO_EN && m_hold >= MH - 1 && others != 0) begin
        m_owner = -1; m_gap = TA; m_tmo = 1'b1;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      found = 1'b0; win = 0;
      for (int k = 0; k < NR; k++)
        if (!found && r[(m_ptr + k) % NR]) begin found = 1'b1; win = (m_ptr + k) % NR; end
      if (found) begin m_owner = win; m_ptr = (win + 1) % NR; m_hold = 0; end
    end
  endtask

  task automatic check_main();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    check("gnt", bif.gnt, eg);
    check("busy", bif.busy, m_owner >= 0);
    check("timeout", bif.timeout, m_tmo);
    if (m_owner >= 0) begin
      check("gnt_id", bif.gnt_id, m_owner);
      check("bus", bus, slice(m_owner));
    end else begin
      check("bus_float", is_float(bus), 1);
    end
    if (m_rd_float) check("bus_rd_float", is_float(bif.bus_rd), 1);
    else            check("bus_rd", bif.bus_rd, m_rd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_main();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (g[i]) r = i;
    return r;
  endfunction

  int         order[$];
  int         rr_exp[5] = '{0, 1, 2, 3, 0};
  int         held;
  int         gap;
  logic [3:0] prev_g;
  logic [3:0] rnd_req;
  logic [3:0] exp_g;
  bit         exp_t;

  initial begin
    rst = 1'b1;
    bif.req = '0;   bif.wr_data  = 32'h5A3C_7E19;
    bif3.req = '0;  bif3.wr_data = 32'h1122_3344;
    model_reset();
    do_reset();

    // idle after reset
    for (int i = 0; i < 10; i++) cycle();
    check("rst_gnt", bif.gnt, 4'b0);
    check("rst_bus_float", is_float(bus), 1);

    // longer turnaround, no preemption, rotation continues after owner 2
    bif3.req = 4'b0100; cycle();
    check("t3_gnt_first", bif3.gnt, 4'b0100);
    bif3.req = 4'b1101; cycle();
    check("t3_no_preempt", bif3.gnt, 4'b0100);
    bif3.req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_gap_gnt", bif3.gnt, 4'b0);
      check("t3_gap_float", is_float(bus3), 1);
    end
    cycle();
    check("t3_next_owner", bif3.gnt, 4'b1000);
    bif3.req = '0;

    // single requester, data on bus, one-cycle gap
    bif.wr_data[15:8] = 8'hA5;
    bif.req = 4'b0010; cycle();
    check("t2_gnt", bif.gnt, 4'b0010);
    check("t2_gnt_id", bif.gnt_id, 1);
    cycle();
    check("t2_bus_rd", bif.bus_rd, 8'hA5);
    bif.req = 4'b0000; cycle();
    check("t2_gap_float", is_float(bus), 1);
    bif.req = 4'b0010; cycle();
    check("t2_regrant", bif.gnt, 4'b0010);

    // full rotation with all requesting
    do_reset();
    bif.req = 4'hF; prev_g = '0; held = 0; gap = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      cycle();
      if (bif.gnt != 0) begin
        if (prev_g == 0) begin
          if (order.size() > 0) check("rr_gap", gap, 1);
          order.push_back(onehot_idx(bif.gnt));
          held = 0; gap = 0;
        end
        held++;
        if (held == 3) bif.req = 4'hF & ~bif.gnt;
      end else begin
        gap++;
        bif.req = 4'hF;
      end
      prev_g = bif.gnt;
    end
    check("rr_len", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) check("rr_order", order[i], rr_exp[i]);

    // async reset between edges
    bif.req = '0;
    repeat (3) cycle();
    bif.req = 4'b0010; cycle(); cycle();
    check("t5_pre_gnt", bif.gnt, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("t5_async_gnt", bif.gnt, 4'b0);
    check("t5_async_busy", bif.busy, 1'b0);
    check("t5_async_bus", is_float(bus), 1);
    check("t5_async_rd", bif.bus_rd, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bif.req = 4'b1001; cycle();
    check("t5_after_rst", bif.gnt, 4'b0001);

    // hold limit
    do_reset();
    bif.req = 4'b0001; cycle();
    check("t6_gnt_1", bif.gnt, 4'b0001);
    bif.req = 4'b0011;
    for (int i = 2; i <= 12; i++) begin
      cycle();
      if (TMO_EN) begin
        exp_g = (i <= 8) ? 4'b0001 : (i == 9) ? 4'b0000 : 4'b0010;
        exp_t = (i == 9);
      end else begin
        exp_g = 4'b0001;
        exp_t = 1'b0;
      end
      check("t6_gnt", bif.gnt, exp_g);
      check("t6_timeout", bif.timeout, exp_t);
    end

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rnd_req = bif.req;
      for (int b = 0; b < NR; b++) begin
        if (rnd_req[b]) begin
          if ($urandom_range(5) == 0) rnd_req[b] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          rnd_req[b] = 1'b1;
        end
      end
      bif.req = rnd_req;
      for (int b = 0; b < NR; b++) bif.wr_data[b*8 +: 8] = 8'($urandom_range(255, 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
